router_ctrl: RTL and testbench
==============================

# router_ctrl

Packet-write controller for the 1x3 router. It decodes the header address and sequences writes of header, payload and parity into one of the three output FIFOs. It stalls the source on full or busy FIFOs. It also times out unread packets by pulsing that FIFO's soft reset. It sits between the input register block and the three router FIFOs.

## Interface
Parameters:
- `TIMEOUT`, 30: consecutive unread cycles before an output's soft reset fires.
- `TW`, 5: width of each timeout counter; must satisfy `2**TW > TIMEOUT`.

Ports:
- `clock` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high reset.
- `pkt_valid` in 1: source has a valid byte.
- `data_in` in 2: header address bits [1:0]; only sampled in DECODE_ADDRESS.
- `parity_done` in 1: register block has captured the parity byte.
- `low_pkt_valid` in 1: `pkt_valid` dropped while the FSM was stalled on full.
- `full` in 3: per-FIFO full flags.
- `empty` in 3: per-FIFO empty flags.
- `read_enb` in 3: per-output read enables from the destination.
- `write_enb` out 3: one-hot FIFO write enable.
- `fifo_full` out 1: `full` of the latched address.
- `vld_out` out 3: `~empty`, combinational.
- `soft_reset` out 3: one-cycle per-FIFO soft reset pulses.
- `busy` out 1: source must hold its current byte.
- `detect_add` out 1: state flag for DECODE_ADDRESS.
- `lfd_state` out 1: state flag for LOAD_FIRST_DATA.
- `ld_state` out 1: state flag for LOAD_DATA.
- `laf_state` out 1: state flag for LOAD_AFTER_FULL.
- `full_state` out 1: state flag for FIFO_FULL_STATE.
- `write_enb_reg` out 1: register block should write this cycle.
- `rst_int_reg` out 1: state flag for CHECK_PARITY_ERROR.

## Operation
- Address latch `addr[1:0]` loads `data_in` when in DECODE_ADDRESS with `pkt_valid=1`. It holds the value otherwise.
- `write_enb[addr] = write_enb_reg`; the other two bits are 0. `fifo_full = full[addr]`.
- Address 3 is invalid: the FSM stays in DECODE_ADDRESS and latches nothing.

State transitions. Reset state is DECODE_ADDRESS. The state register updates on the clock edge.
- DECODE_ADDRESS (`detect_add`):
  - `pkt_valid` with `data_in!=3` and `empty[data_in]=1` -> LOAD_FIRST_DATA.
  - `pkt_valid` with `data_in!=3` and `empty[data_in]=0` -> WAIT_TILL_EMPTY.
- LOAD_FIRST_DATA (`lfd_state`, `busy`): -> LOAD_DATA unconditionally.
- LOAD_DATA (`ld_state`, `write_enb_reg`, `busy=0`):
  - `fifo_full` -> FIFO_FULL_STATE.
  - else `!pkt_valid` -> LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE (`full_state`, `busy`, no write): `!fifo_full` -> LOAD_AFTER_FULL.
- LOAD_AFTER_FULL (`laf_state`, `busy`, `write_enb_reg`):
  - `parity_done` -> DECODE_ADDRESS.
  - else `low_pkt_valid` -> LOAD_PARITY.
  - else -> LOAD_DATA.
- LOAD_PARITY (`busy`, `write_enb_reg`): -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR (`rst_int_reg`, `busy`):
  - `fifo_full` -> FIFO_FULL_STATE.
  - else -> DECODE_ADDRESS.
- WAIT_TILL_EMPTY (`busy`, no write): `empty[addr]` -> LOAD_FIRST_DATA.
- `lfd_state` drives the FIFO header marker. `write_enb_reg` is asserted in LOAD_FIRST_DATA as well.

Priority:
- `reset` overrides everything.
- Next, `soft_reset[addr]` forces DECODE_ADDRESS from any state (when `ROUTER_TIMEOUT_EN` is defined).
- Next, the listed transitions.

## Timing
- Reset values:
  - state DECODE_ADDRESS, so `detect_add=1`.
  - All other state flags, `busy`, `write_enb`, `write_enb_reg` and `soft_reset` are 0.
  - `addr=0`; timeout counters 0.
  - `vld_out` and `fifo_full` follow their inputs combinationally.
- All state flags, `busy`, `write_enb` and `write_enb_reg` are Moore outputs decoded from the state register. Their latency is 0 cycles after the state edge.
- Header write: the header byte is presented with `pkt_valid` in DECODE_ADDRESS. It is written in the LOAD_FIRST_DATA cycle, 1 cycle after the address is accepted.
- `busy` goes high in the same cycle the FSM enters a stalling state. The source holds `data_in` while `busy=1`.
- Simultaneous full deassertion and `soft_reset`: the soft reset wins.
- Reset mid-packet: the next cycle is DECODE_ADDRESS with no write; the partial packet is abandoned.

## Configuration
- `ROUTER_TIMEOUT_EN` defined:
  - Per output `i`, counter `cnt[i]` increments each cycle while `vld_out[i]=1` and `read_enb[i]=0`.
  - `cnt[i]` clears when `read_enb[i]=1` or `vld_out[i]=0`.
  - When `cnt[i]==TIMEOUT-1`, `soft_reset[i]` pulses high for 1 cycle and `cnt[i]` clears.
  - The first pulse therefore lands in cycle `TIMEOUT` of idle valid data.
- `ROUTER_TIMEOUT_EN` undefined: `soft_reset` is tied to 0, the counters are not built, and the soft-reset FSM override is absent.

## Test plan
- Reset, then a header with address 1 (`data_in=2'b01`), length 4, into empty FIFOs:
  - `write_enb=3'b010` for 6 cycles: header, 4 payload, parity.
  - `lfd_state` is high for the header cycle only.
  - Sequence ends CHECK_PARITY_ERROR -> DECODE_ADDRESS.
- Header with address 0 while `empty[0]=0`:
  - FSM enters WAIT_TILL_EMPTY with `busy=1` and `write_enb=0`.
  - It moves to LOAD_FIRST_DATA 1 cycle after `empty[0]` rises.
- Force `full[2]=1` mid-payload:
  - Next state is FIFO_FULL_STATE with `busy=1` and no writes.
  - After `full[2]` drops: LOAD_AFTER_FULL, then LOAD_DATA; no byte is lost or duplicated.
- Header with `data_in=2'b11`: FSM stays in DECODE_ADDRESS and `write_enb` stays 0.
- With `ROUTER_TIMEOUT_EN`, `empty[1]=0` and `read_enb[1]=0`:
  - `soft_reset[1]` pulses high for exactly 1 cycle, 30 cycles after `vld_out[1]` rose.
  - A read in cycle 29 suppresses the pulse.
- Assert `reset` in LOAD_DATA: the next cycle is DECODE_ADDRESS with `detect_add=1` and all writes 0.

Source files
------------

// File: rtl/router_ctrl.sv
// Packet-write FSM for the 1x3 router: decodes the header address, sequences header/payload/parity
// writes into one output FIFO, and stalls the source. Optional per-output timeout under ROUTER_TIMEOUT_EN.
module router_ctrl #(
  parameter int TIMEOUT = 30,
  parameter int TW      = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic [2:0] full,
  input  logic [2:0] empty,
  input  logic [2:0] read_enb,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic [2:0] vld_out,
  output logic [2:0] soft_reset,
  output logic       busy,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
  } state_t;

  state_t     state, next_state;
  logic [1:0] addr;

  // Address 3 has no FIFO behind it, so it selects nothing.
  function automatic logic pick(input logic [2:0] v, input logic [1:0] a);
    case (a)
      2'd0:    pick = v[0];
      2'd1:    pick = v[1];
      2'd2:    pick = v[2];
      default: pick = 1'b0;
    endcase
  endfunction

  assign vld_out   = ~empty;
  assign fifo_full = pick(full, addr);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= DECODE_ADDRESS;
      addr  <= 2'd0;
    end else begin
      state <= next_state;
      if (state == DECODE_ADDRESS && pkt_valid && data_in != 2'd3)
        addr <= data_in;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      DECODE_ADDRESS:
        if (pkt_valid && data_in != 2'd3)
          next_state = pick(empty, data_in) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA: next_state = LOAD_DATA;
      LOAD_DATA:
        if (fifo_full)       next_state = FIFO_FULL_STATE;
        else if (!pkt_valid) next_state = LOAD_PARITY;
      FIFO_FULL_STATE:
        if (!fifo_full) next_state = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (parity_done)        next_state = DECODE_ADDRESS;
        else if (low_pkt_valid) next_state = LOAD_PARITY;
        else                    next_state = LOAD_DATA;
      LOAD_PARITY:        next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY:
        if (pick(empty, addr)) next_state = LOAD_FIRST_DATA;
      default: next_state = DECODE_ADDRESS;
    endcase
`ifdef ROUTER_TIMEOUT_EN
    // A timed-out destination abandons whatever packet is in flight.
    if (pick(soft_reset, addr)) next_state = DECODE_ADDRESS;
`endif
  end

  always_comb begin
    detect_add    = (state == DECODE_ADDRESS);
    lfd_state     = (state == LOAD_FIRST_DATA);
    ld_state      = (state == LOAD_DATA);
    laf_state     = (state == LOAD_AFTER_FULL);
    full_state    = (state == FIFO_FULL_STATE);
    rst_int_reg   = (state == CHECK_PARITY_ERROR);
    write_enb_reg = lfd_state || ld_state || laf_state || (state == LOAD_PARITY);
    busy          = !(detect_add || ld_state);
    write_enb     = 3'b000;
    case (addr)
      2'd0:    write_enb[0] = write_enb_reg;
      2'd1:    write_enb[1] = write_enb_reg;
      2'd2:    write_enb[2] = write_enb_reg;
      default: write_enb    = 3'b000;
    endcase
  end

`ifdef ROUTER_TIMEOUT_EN
  logic [TW-1:0] cnt [3];

  // The pulse is registered, so it lands one cycle after the counter reaches TIMEOUT-1.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        cnt[i]        <= '0;
        soft_reset[i] <= 1'b0;
      end else if (vld_out[i] && !read_enb[i]) begin
        if (cnt[i] == TW'(TIMEOUT - 1)) begin
          cnt[i]        <= '0;
          soft_reset[i] <= 1'b1;
        end else begin
          cnt[i]        <= cnt[i] + 1'b1;
          soft_reset[i] <= 1'b0;
        end
      end else begin
        cnt[i]        <= '0;
        soft_reset[i] <= 1'b0;
      end
    end
  end
`else
  assign soft_reset = 3'b000;
`endif

endmodule

// File: tb/tb_router_ctrl.sv
// Self-checking bench for router_ctrl: table of per-cycle vectors plus hand-written timeout sequences.
module tb_router_ctrl;

  logic       clock = 1'b0;
  logic       reset, pkt_valid, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic [2:0] full, empty, read_enb;
  logic [2:0] write_enb, vld_out, soft_reset;
  logic       fifo_full, busy, detect_add, lfd_state, ld_state, laf_state;
  logic       full_state, write_enb_reg, rst_int_reg;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  router_ctrl #(.TIMEOUT(30), .TW(5)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .full(full),
    .empty(empty), .read_enb(read_enb), .write_enb(write_enb), .fifo_full(fifo_full),
    .vld_out(vld_out), .soft_reset(soft_reset), .busy(busy), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg)
  );

  // Flag order: detect_add, lfd, ld, laf, full_state, rst_int_reg, busy, write_enb_reg
  localparam logic [7:0] DA  = 8'b1000_0000;
  localparam logic [7:0] LFD = 8'b0100_0011;
  localparam logic [7:0] LD  = 8'b0010_0001;
  localparam logic [7:0] LAF = 8'b0001_0011;
  localparam logic [7:0] FFS = 8'b0000_1010;
  localparam logic [7:0] LP  = 8'b0000_0011;
  localparam logic [7:0] CPE = 8'b0000_0110;
  localparam logic [7:0] WTE = 8'b0000_0010;

  typedef struct {
    logic       rst;
    logic       pv;
    logic [1:0] d;
    logic       pd;
    logic       lpv;
    logic [2:0] full;
    logic [2:0] empty;
    logic [7:0] flags;
    logic [2:0] we;
    logic       ff;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic pv, input logic [1:0] d, input logic pd,
                     input logic lpv, input logic [2:0] f, input logic [2:0] e,
                     input logic [7:0] flags, input logic [2:0] we, input logic ff);
    vec_t v;
    v.rst = rst; v.pv = pv; v.d = d; v.pd = pd; v.lpv = lpv; v.full = f; v.empty = e;
    v.flags = flags; v.we = we; v.ff = ff;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic rst, input logic pv, input logic [1:0] d, input logic pd,
                       input logic lpv, input logic [2:0] f, input logic [2:0] e,
                       input logic [2:0] rd);
    @(negedge clock);
    reset = rst; pkt_valid = pv; data_in = d; parity_done = pd; low_pkt_valid = lpv;
    full = f; empty = e; read_enb = rd;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [10:0] observed();
    return {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
            busy, write_enb_reg, write_enb};
  endfunction

  initial begin
    reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; parity_done = 1'b0;
    low_pkt_valid = 1'b0; full = 3'b000; empty = 3'b111; read_enb = 3'b000;

    // Address 1, four payload bytes, empty FIFOs
    add(1, 0, 0, 0, 0, 3'b000, 3'b111, DA,  3'b000, 0);
    add(0, 1, 1, 0, 0, 3'b000, 3'b111, LFD, 3'b010, 0);
    add(0, 1, 1, 0, 0, 3'b000, 3'b111, LD,  3'b010, 0);
    add(0, 1, 1, 0, 0, 3'b000, 3'b111, LD,  3'b010, 0);
    add(0, 1, 1, 0, 0, 3'b000, 3'b111, LD,  3'b010, 0);
    add(0, 1, 1, 0, 0, 3'b000, 3'b111, LD,  3'b010, 0);
    add(0, 0, 1, 0, 0, 3'b000, 3'b111, LP,  3'b010, 0);
    add(0, 0, 1, 0, 0, 3'b000, 3'b111, CPE, 3'b000, 0);
    add(0, 0, 1, 0, 0, 3'b000, 3'b111, DA,  3'b000, 0);
    // Invalid address 3 is ignored
    add(0, 1, 3, 0, 0, 3'b000, 3'b111, DA,  3'b000, 0);
    add(0, 0, 0, 0, 0, 3'b000, 3'b111, DA,  3'b000, 0);
    // Address 0 while FIFO 0 still holds data
    add(0, 1, 0, 0, 0, 3'b000, 3'b110, WTE, 3'b000, 0);
    add(0, 1, 0, 0, 0, 3'b000, 3'b110, WTE, 3'b000, 0);
    add(0, 1, 0, 0, 0, 3'b000, 3'b111, LFD, 3'b001, 0);
    add(0, 1, 0, 0, 0, 3'b000, 3'b111, LD,  3'b001, 0);
    add(0, 0, 0, 0, 0, 3'b000, 3'b111, LP,  3'b001, 0);
    add(0, 0, 0, 0, 0, 3'b000, 3'b111, CPE, 3'b000, 0);
    add(0, 0, 0, 0, 0, 3'b000, 3'b111, DA,  3'b000, 0);
    // Address 2, FIFO 2 fills mid-payload
    add(0, 1, 2, 0, 0, 3'b000, 3'b111, LFD, 3'b100, 0);
    add(0, 1, 2, 0, 0, 3'b000, 3'b111, LD,  3'b100, 0);
    add(0, 1, 2, 0, 0, 3'b100, 3'b111, FFS, 3'b000, 1);
    add(0, 1, 2, 0, 0, 3'b100, 3'b111, FFS, 3'b000, 1);
    add(0, 1, 2, 0, 0, 3'b000, 3'b111, LAF, 3'b100, 0);
    add(0, 1, 2, 0, 0, 3'b000, 3'b111, LD,  3'b100, 0);
    add(0, 0, 2, 0, 0, 3'b000, 3'b111, LP,  3'b100, 0);
    add(0, 0, 2, 0, 0, 3'b000, 3'b111, CPE, 3'b000, 0);
    add(0, 0, 2, 0, 0, 3'b000, 3'b111, DA,  3'b000, 0);
    // Full during parity check, then low_pkt_valid after the stall
    add(0, 1, 2, 0, 0, 3'b000, 3'b111, LFD, 3'b100, 0);
    add(0, 0, 2, 0, 0, 3'b000, 3'b111, LD,  3'b100, 0);
    add(0, 0, 2, 0, 0, 3'b000, 3'b111, LP,  3'b100, 0);
    add(0, 0, 2, 0, 0, 3'b100, 3'b111, CPE, 3'b000, 1);
    add(0, 0, 2, 0, 0, 3'b100, 3'b111, FFS, 3'b000, 1);
    add(0, 0, 2, 0, 1, 3'b000, 3'b111, LAF, 3'b100, 0);
    add(0, 0, 2, 0, 1, 3'b000, 3'b111, LP,  3'b100, 0);
    add(0, 0, 2, 0, 0, 3'b000, 3'b111, CPE, 3'b000, 0);
    add(0, 0, 2, 0, 0, 3'b000, 3'b111, DA,  3'b000, 0);
    // parity_done out of LOAD_AFTER_FULL
    add(0, 1, 1, 0, 0, 3'b000, 3'b111, LFD, 3'b010, 0);
    add(0, 1, 1, 0, 0, 3'b010, 3'b111, LD,  3'b010, 1);
    add(0, 1, 1, 0, 0, 3'b010, 3'b111, FFS, 3'b000, 1);
    add(0, 1, 1, 0, 0, 3'b000, 3'b111, LAF, 3'b010, 0);
    add(0, 0, 1, 1, 0, 3'b000, 3'b111, DA,  3'b000, 0);
    // Reset in LOAD_DATA abandons the packet and clears addr
    add(0, 1, 1, 0, 0, 3'b000, 3'b111, LFD, 3'b010, 0);
    add(0, 1, 1, 0, 0, 3'b000, 3'b111, LD,  3'b010, 0);
    add(1, 1, 1, 0, 0, 3'b000, 3'b111, DA,  3'b000, 0);
    add(0, 0, 0, 0, 0, 3'b010, 3'b111, DA,  3'b000, 0);
    add(0, 0, 0, 0, 0, 3'b001, 3'b111, DA,  3'b000, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].pv, vecs[i].d, vecs[i].pd, vecs[i].lpv,
            vecs[i].full, vecs[i].empty, 3'b000);
      check($sformatf("vec%0d_state", i), 32'(observed()), 32'({vecs[i].flags, vecs[i].we}));
      check($sformatf("vec%0d_fifo_full", i), 32'(fifo_full), 32'(vecs[i].ff));
      check($sformatf("vec%0d_soft_reset", i), 32'(soft_reset), 32'd0);
    end

    drive(0, 0, 0, 0, 0, 3'b000, 3'b101, 3'b000);
    check("vld_out_pattern", 32'(vld_out), 32'b010);

`ifdef ROUTER_TIMEOUT_EN
    // FSM waits on address 1 while FIFO 1 is never read; the timeout must free it
    drive(1, 0, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    drive(0, 1, 1, 0, 0, 3'b000, 3'b101, 3'b000);
    check("to_wait_state", 32'(observed()), 32'({WTE, 3'b000}));
    for (int k = 2; k <= 29; k++) begin
      drive(0, 0, 1, 0, 0, 3'b000, 3'b101, 3'b000);
      check($sformatf("to_quiet_e%0d", k), 32'(soft_reset), 32'd0);
    end
    drive(0, 0, 1, 0, 0, 3'b000, 3'b101, 3'b000);
    check("to_pulse", 32'(soft_reset), 32'b010);
    check("to_still_waiting", 32'(observed()), 32'({WTE, 3'b000}));
    drive(0, 0, 1, 0, 0, 3'b000, 3'b101, 3'b000);
    check("to_pulse_width", 32'(soft_reset), 32'd0);
    check("to_fsm_released", 32'(detect_add), 32'd1);

    // A read in cycle 29 suppresses the pulse
    drive(1, 0, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    for (int k = 1; k <= 29; k++) drive(0, 0, 0, 0, 0, 3'b000, 3'b101, 3'b000);
    check("sup_before", 32'(soft_reset), 32'd0);
    drive(0, 0, 0, 0, 0, 3'b000, 3'b101, 3'b010);
    check("sup_e30", 32'(soft_reset), 32'd0);
    drive(0, 0, 0, 0, 0, 3'b000, 3'b101, 3'b000);
    check("sup_e31", 32'(soft_reset), 32'd0);
`else
    drive(1, 0, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    for (int k = 1; k <= 40; k++) begin
      drive(0, 0, 0, 0, 0, 3'b000, 3'b101, 3'b000);
      check($sformatf("no_timeout_e%0d", k), 32'(soft_reset), 32'd0);
    end
`endif

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
